nios_sys_led_pio_ctrl: RTL and testbench

//  Parametrised Avalon-MM output PIO for board LEDs; successor to the fixed 18-bit LED register.

---
 rtl/nios_sys_led_pio_ctrl_pkg.sv | 16 +
 rtl/nios_sys_led_blink_timer.sv | 34 +++
 rtl/nios_sys_led_pio_ctrl.sv | 111 +++++++++++
 tb/tb_nios_sys_led_pio_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nios_sys_led_pio_ctrl_pkg.sv
// Shared register map and constants for the LED PIO controller.
// Build option NIOS_SYS_LED_PIO_PWM_EN enables the DUTY register and PWM dimming.
package nios_sys_led_pio_ctrl_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_SET      = 3'd1;
   localparam logic [2:0] ADDR_CLEAR    = 3'd2;
   localparam logic [2:0] ADDR_TOGGLE   = 3'd3;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd4;
   localparam logic [2:0] ADDR_PERIOD   = 3'd5;
   localparam logic [2:0] ADDR_DUTY     = 3'd6;

   localparam int         DUTY_W        = 8;
   localparam logic [7:0] DUTY_RESET    = 8'hFF;

endpackage

// File: rtl/nios_sys_led_blink_timer.sv
// Blink prescaler: divides clk by PERIOD and toggles a shared blink phase.
// PERIOD of zero halts the timer with the phase parked high (blinking LEDs lit).
module nios_sys_led_blink_timer #(
   parameter int PRESC_W = 24
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [PRESC_W-1:0] period,
   input  logic               period_wr,
   output logic               phase
);

   logic [PRESC_W-1:0] presc_cnt;

   // period is the value PERIOD holds after this edge, so writing 0 parks the phase immediately.
   // The >= compare lets a lowered PERIOD wrap right away instead of counting through 2^PRESC_W.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_cnt <= '0;
         phase     <= 1'b1;
      end else if (period == '0) begin
         presc_cnt <= '0;
         phase     <= 1'b1;
      end else if (period_wr) begin
         presc_cnt <= '0;
      end else if (presc_cnt >= period - PRESC_W'(1)) begin
         presc_cnt <= '0;
         phase     <= ~phase;
      end else begin
         presc_cnt <= presc_cnt + PRESC_W'(1);
      end
   end

endmodule

// File: rtl/nios_sys_led_pio_ctrl.sv
// Avalon-MM LED output PIO with set/clear/toggle aliases, per-bit blink and optional PWM.
// Define NIOS_SYS_LED_PIO_PWM_EN to add the DUTY register and global dimming.
module nios_sys_led_pio_ctrl
   import nios_sys_led_pio_ctrl_pkg::*;
#(
   parameter int               WIDTH       = 18,
   parameter int               PRESC_W     = 24,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic               wr;
   logic [WIDTH-1:0]   wd_bits;
   logic [PRESC_W-1:0] wd_period;
   logic [WIDTH-1:0]   data_out;
   logic [WIDTH-1:0]   blink_en;
   logic [PRESC_W-1:0] period;
   logic               period_wr;
   logic [PRESC_W-1:0] period_next;
   logic               phase;
   logic [WIDTH-1:0]   logical;
   logic               unused_wd;

   assign wr        = chipselect & ~write_n;
   assign wd_bits   = writedata[WIDTH-1:0];
   assign wd_period = writedata[PRESC_W-1:0];
   assign unused_wd = ^writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= RESET_VALUE;
      end else if (wr) begin
         case (address)
            ADDR_DATA:   data_out <= wd_bits;
            ADDR_SET:    data_out <= data_out | wd_bits;
            ADDR_CLEAR:  data_out <= data_out & ~wd_bits;
            ADDR_TOGGLE: data_out <= data_out ^ wd_bits;
            default:     data_out <= data_out;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_en <= '0;
         period   <= '0;
      end else if (wr) begin
         if (address == ADDR_BLINK_EN) blink_en <= wd_bits;
         if (address == ADDR_PERIOD)   period   <= wd_period;
      end
   end

   assign period_wr   = wr && (address == ADDR_PERIOD);
   assign period_next = period_wr ? wd_period : period;

   nios_sys_led_blink_timer #(
      .PRESC_W (PRESC_W)
   ) u_blink_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .period    (period_next),
      .period_wr (period_wr),
      .phase     (phase)
   );

   assign logical = data_out & (~blink_en | {WIDTH{phase}});

`ifdef NIOS_SYS_LED_PIO_PWM_EN
   logic [DUTY_W-1:0] duty;
   logic [7:0]        pwm_cnt;
   logic              pwm_on;

   // pwm_cnt free-runs regardless of DUTY writes so the dimming period never jitters.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty    <= DUTY_RESET;
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (wr && (address == ADDR_DUTY)) duty <= writedata[DUTY_W-1:0];
      end
   end

   assign pwm_on   = (duty == 8'hFF) | (pwm_cnt < duty);
   assign out_port = logical & {WIDTH{pwm_on}};
`else
   assign out_port = logical;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:     readdata = 32'(data_out);
         ADDR_BLINK_EN: readdata = 32'(blink_en);
         ADDR_PERIOD:   readdata = 32'(period);
`ifdef NIOS_SYS_LED_PIO_PWM_EN
         ADDR_DUTY:     readdata = 32'(duty);
`endif
         default:       readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_nios_sys_led_pio_ctrl.sv
// Directed bench for nios_sys_led_pio_ctrl: register table plus blink, reset and PWM sequences.
// Expectations for offset 6 follow NIOS_SYS_LED_PIO_PWM_EN when it is defined for the build.
module tb_nios_sys_led_pio_ctrl;

`ifdef NIOS_SYS_LED_PIO_PWM_EN
   localparam bit PWM = 1'b1;
`else
   localparam bit PWM = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [17:0] out_port;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        do_wr;
      logic [2:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [17:0] exp_out;
   } vec_t;

   vec_t vecs [0:16];

   nios_sys_led_pio_ctrl #(
      .WIDTH       (18),
      .PRESC_W     (24),
      .RESET_VALUE (18'h0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic read_check(input string name, input logic [2:0] a,
                             input logic [31:0] exp_rd, input logic [17:0] exp_out);
      address    = a;
      chipselect = 1'b1;
      #1;
      check_output({name, "_rd"}, readdata, exp_rd);
      check_output({name, "_out"}, 32'(out_port), 32'(exp_out));
      chipselect = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int ones;

      vecs[0]  = '{1'b0, 3'd0, 32'h0,        32'h0,      18'h0};
      vecs[1]  = '{1'b0, 3'd4, 32'h0,        32'h0,      18'h0};
      vecs[2]  = '{1'b0, 3'd5, 32'h0,        32'h0,      18'h0};
      vecs[3]  = '{1'b1, 3'd0, 32'h3FFFF,    32'h3FFFF,  18'h3FFFF};
      vecs[4]  = '{1'b1, 3'd0, 32'hFFFFFFFF, 32'h3FFFF,  18'h3FFFF};
      vecs[5]  = '{1'b1, 3'd0, 32'h000F0,    32'h000F0,  18'h000F0};
      vecs[6]  = '{1'b1, 3'd1, 32'h00003,    32'h0,      18'h000F3};
      vecs[7]  = '{1'b1, 3'd2, 32'h00030,    32'h0,      18'h000C3};
      vecs[8]  = '{1'b1, 3'd3, 32'h000FF,    32'h0,      18'h0003C};
      vecs[9]  = '{1'b0, 3'd0, 32'h0,        32'h0003C,  18'h0003C};
      vecs[10] = '{1'b1, 3'd7, 32'h0FFFF,    32'h0,      18'h0003C};
      vecs[11] = '{1'b1, 3'd6, 32'h0,        32'h0,      PWM ? 18'h0 : 18'h0003C};
      vecs[12] = '{1'b1, 3'd6, 32'hFF,       PWM ? 32'hFF : 32'h0, 18'h0003C};
      vecs[13] = '{1'b1, 3'd4, 32'h5,        32'h5,      18'h0003C};
      vecs[14] = '{1'b1, 3'd5, 32'h12345678, 32'h345678, 18'h0003C};
      vecs[15] = '{1'b1, 3'd5, 32'h0,        32'h0,      18'h0003C};
      vecs[16] = '{1'b1, 3'd4, 32'h0,        32'h0,      18'h0003C};

      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      #23 reset_n = 1'b1;
      tick(1);

      for (int i = 0; i <= 16; i++) begin
         if (vecs[i].do_wr) apply_stimulus(vecs[i].addr, vecs[i].wd);
         read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_rd, vecs[i].exp_out);
      end

      // Blink at PERIOD=4: bits 0 and 2 toggle every 4 clocks, bits 1 and 3 stay lit.
      apply_stimulus(3'd0, 32'hF);
      apply_stimulus(3'd4, 32'h5);
      apply_stimulus(3'd5, 32'd4);
      for (int k = 0; k < 16; k++) begin
         check_output($sformatf("blink4_k%0d", k), 32'(out_port), ((k / 4) % 2 == 0) ? 32'hF : 32'hA);
         tick(1);
      end

      // Rewriting PERIOD restarts the prescaler; zero parks blinking bits on.
      apply_stimulus(3'd5, 32'd0);
      check_output("period0_park", 32'(out_port), 32'hF);
      apply_stimulus(3'd5, 32'd100);
      tick(49);
      check_output("period100_k49", 32'(out_port), 32'hF);
      apply_stimulus(3'd5, 32'd10);
      for (int j = 0; j < 10; j++) begin
         check_output($sformatf("period10_j%0d", j), 32'(out_port), 32'hF);
         tick(1);
      end
      check_output("period10_toggle", 32'(out_port), 32'hA);
      apply_stimulus(3'd5, 32'd0);
      check_output("period0_held", 32'(out_port), 32'hF);
      tick(20);
      check_output("period0_held20", 32'(out_port), 32'hF);

      // Asynchronous reset in the dark half of a blink.
      apply_stimulus(3'd0, 32'h3);
      apply_stimulus(3'd4, 32'h1);
      apply_stimulus(3'd5, 32'd3);
      check_output("rst_pre_k0", 32'(out_port), 32'h3);
      tick(3);
      check_output("rst_pre_k3", 32'(out_port), 32'h2);
      #2 reset_n = 1'b0;
      #1;
      check_output("rst_async_out", 32'(out_port), 32'h0);
      read_check("rst_data", 3'd0, 32'h0, 18'h0);
      read_check("rst_blink", 3'd4, 32'h0, 18'h0);
      read_check("rst_period", 3'd5, 32'h0, 18'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick(1);
      apply_stimulus(3'd0, 32'h1);
      apply_stimulus(3'd4, 32'h1);
      apply_stimulus(3'd5, 32'd4);
      check_output("rst_phase_k0", 32'(out_port), 32'h1);
      tick(3);
      check_output("rst_phase_k3", 32'(out_port), 32'h1);
      tick(1);
      check_output("rst_phase_k4", 32'(out_port), 32'h0);

      // PWM duty measured over one full 256-clock pwm period.
      apply_stimulus(3'd5, 32'd0);
      apply_stimulus(3'd4, 32'h0);
      apply_stimulus(3'd0, 32'h1);
      apply_stimulus(3'd6, 32'd64);
      read_check("duty64", 3'd6, PWM ? 32'd64 : 32'd0, out_port);
      ones = 0;
      for (int c = 0; c < 256; c++) begin
         if (out_port[0]) ones++;
         tick(1);
      end
      check_output("pwm_duty64", 32'(ones), PWM ? 32'd64 : 32'd256);
      apply_stimulus(3'd6, 32'd0);
      ones = 0;
      for (int c = 0; c < 256; c++) begin
         if (out_port[0]) ones++;
         tick(1);
      end
      check_output("pwm_duty0", 32'(ones), PWM ? 32'd0 : 32'd256);
      apply_stimulus(3'd6, 32'd255);
      ones = 0;
      for (int c = 0; c < 256; c++) begin
         if (out_port[0]) ones++;
         tick(1);
      end
      check_output("pwm_duty255", 32'(ones), 32'd256);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
